dispatch_rename_ctrl: RTL and testbench

- Sequences the register file's reservation and commit ports; sits between decode/dispatch and the rename register file.
- Allocates reservation IDs, drives rsv/rob_id on dispatch and we/wrData on commit, and tracks the in-flight count against ROB capacity.
- Serialises fence instructions and sequences branch-miss flushes.

---
 rtl/fcpu_pkg.sv | 6 +
 rtl/dispatch_rename_ctrl.sv | 130 +++++++++++++
 tb/tb_dispatch_rename_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcpu_pkg.sv
// Shared widths for the fcpu core: reservation ID, datapath and register address.
package fcpu_pkg;
  localparam int RSV_ID_W   = 4;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
endpackage

// File: rtl/dispatch_rename_ctrl.sv
// Dispatch/commit sequencer in front of the rename register file: ID allocation, ROB occupancy,
// fence serialisation and branch-miss flush. Optional DISPATCH_RENAME_CTRL_STALL_CNT_EN adds stall_cnt.
module dispatch_rename_ctrl
  import fcpu_pkg::*;
#(
  parameter int ROB_DEPTH = 15  // must not exceed 2**RSV_ID_W-1 so live IDs stay unique
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic                               disp_has_dst,
  input  logic [REG_ADDR_W-1:0]              disp_dst,
  input  logic                               disp_fence,
  output logic [RSV_ID_W-1:0]                disp_id,
  output logic                               rsv,
  output logic [RSV_ID_W-1:0]                rob_id,
  output logic [REG_ADDR_W-1:0]              rsv_addr,
  input  logic                               cmt_valid,
  input  logic                               cmt_dst_en,
  input  logic [REG_ADDR_W-1:0]              cmt_dst,
  input  logic [DATA_W-1:0]                  cmt_data,
  output logic                               we,
  output logic [DATA_W+RSV_ID_W-1:0]         wrData,
  input  logic                               branch_miss_in,
  output logic                               branch_miss,
  output logic [$clog2(ROB_DEPTH+1)-1:0]     inflight,
  output logic [1:0]                         state,
`ifdef DISPATCH_RENAME_CTRL_STALL_CNT_EN
  output logic [15:0]                        stall_cnt,
`endif
  output logic                               cmt_err
);

  localparam int CNT_W = $clog2(ROB_DEPTH+1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FENCE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } state_e;

  state_e              state_q;
  logic [RSV_ID_W-1:0] next_id_q, next_id_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic                cmt_err_q;

  logic                fire;
  logic                cmt_acc;
  logic                not_empty;
  logic                room;
  logic [RSV_ID_W-1:0] cmt_dst_ext;

  // ID 0 means "no reservation" in the regfile, so the sequence wraps to 1.
  function automatic logic [RSV_ID_W-1:0] id_incr(input logic [RSV_ID_W-1:0] id);
    if (id == '1) return RSV_ID_W'(1);
    return id + RSV_ID_W'(1);
  endfunction

  assign not_empty = (inflight_q != '0);
  assign room      = (inflight_q < CNT_W'(ROB_DEPTH));

  // Ready looks only at registered occupancy; a same-cycle commit frees space next cycle.
  always_comb begin
    disp_ready = 1'b0;
    if (nrst && state_q == RUN)
      disp_ready = room & ~branch_miss_in & ~(disp_fence & not_empty);
  end

  assign fire    = disp_valid & disp_ready;
  assign cmt_acc = nrst & cmt_valid & not_empty;

  assign rsv         = fire & disp_has_dst;
  assign disp_id     = nrst ? next_id_q : '0;
  assign rob_id      = nrst ? next_id_q : '0;
  assign rsv_addr    = nrst ? disp_dst : '0;
  assign cmt_dst_ext = RSV_ID_W'(cmt_dst);
  assign we          = cmt_acc & cmt_dst_en;
  assign wrData      = nrst ? {cmt_dst_ext, cmt_data} : '0;
  assign branch_miss = nrst & branch_miss_in;

  assign inflight = inflight_q;
  assign state    = state_q;
  assign cmt_err  = cmt_err_q;

  // A flush discards every younger entry; the committing one is older and still retires.
  always_comb begin
    inflight_d = inflight_q + CNT_W'(fire) - CNT_W'(cmt_acc);
    if (branch_miss_in) inflight_d = '0;
    next_id_d = fire ? id_incr(next_id_q) : next_id_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= RUN;
      inflight_q <= '0;
      next_id_q  <= RSV_ID_W'(1);
      cmt_err_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      next_id_q  <= next_id_d;
      if (cmt_valid && !not_empty) cmt_err_q <= 1'b1;
      if (branch_miss_in) begin
        state_q <= FLUSH;
      end else begin
        case (state_q)
          RUN:        if (disp_valid && disp_fence && not_empty) state_q <= FENCE_WAIT;
          FENCE_WAIT: if (!not_empty) state_q <= RUN;
          FLUSH:      state_q <= RUN;
          default:    state_q <= RUN;
        endcase
      end
    end
  end

`ifdef DISPATCH_RENAME_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt_q <= '0;
    end else if (disp_valid && !disp_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_rename_ctrl.sv
// Scoreboard bench for dispatch_rename_ctrl: directed vectors push expected dispatch/commit
// transactions; a negedge monitor pops them whenever the DUT fires or writes.
module tb_dispatch_rename_ctrl;
  import fcpu_pkg::*;

  localparam int ROB_DEPTH = 15;
  localparam int CNT_W     = $clog2(ROB_DEPTH+1);

  logic                         clk = 1'b0;
  logic                         nrst = 1'b0;
  logic                         disp_valid = 1'b0;
  logic                         disp_ready;
  logic                         disp_has_dst = 1'b0;
  logic [REG_ADDR_W-1:0]        disp_dst = '0;
  logic                         disp_fence = 1'b0;
  logic [RSV_ID_W-1:0]          disp_id;
  logic                         rsv;
  logic [RSV_ID_W-1:0]          rob_id;
  logic [REG_ADDR_W-1:0]        rsv_addr;
  logic                         cmt_valid = 1'b0;
  logic                         cmt_dst_en = 1'b0;
  logic [REG_ADDR_W-1:0]        cmt_dst = '0;
  logic [DATA_W-1:0]            cmt_data = '0;
  logic                         we;
  logic [DATA_W+RSV_ID_W-1:0]   wrData;
  logic                         branch_miss_in = 1'b0;
  logic                         branch_miss;
  logic [CNT_W-1:0]             inflight;
  logic [1:0]                   state;
  logic                         cmt_err;
`ifdef DISPATCH_RENAME_CTRL_STALL_CNT_EN
  logic [15:0]                  stall_cnt;
`endif

  always #5 clk = ~clk;

  dispatch_rename_ctrl #(.ROB_DEPTH(ROB_DEPTH)) dut (
    .clk(clk), .nrst(nrst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_has_dst(disp_has_dst),
    .disp_dst(disp_dst), .disp_fence(disp_fence), .disp_id(disp_id),
    .rsv(rsv), .rob_id(rob_id), .rsv_addr(rsv_addr),
    .cmt_valid(cmt_valid), .cmt_dst_en(cmt_dst_en), .cmt_dst(cmt_dst), .cmt_data(cmt_data),
    .we(we), .wrData(wrData),
    .branch_miss_in(branch_miss_in), .branch_miss(branch_miss),
    .inflight(inflight), .state(state),
`ifdef DISPATCH_RENAME_CTRL_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .cmt_err(cmt_err)
  );

  typedef struct packed {
    logic [RSV_ID_W-1:0]   id;
    logic                  rsv;
    logic [REG_ADDR_W-1:0] addr;
  } disp_exp_t;

  disp_exp_t                  disp_q[$];
  logic [DATA_W+RSV_ID_W-1:0] cmt_q[$];
  disp_exp_t                  mon_d;
  logic [DATA_W+RSV_ID_W-1:0] mon_c;
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic exp_disp(input logic [RSV_ID_W-1:0] id, input logic r, input logic [REG_ADDR_W-1:0] a);
    disp_q.push_back('{id: id, rsv: r, addr: a});
  endtask

  task automatic exp_cmt(input logic [REG_ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
    logic [RSV_ID_W-1:0] dx;
    dx = RSV_ID_W'(d);
    cmt_q.push_back({dx, v});
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic hd, input logic [REG_ADDR_W-1:0] dst,
                       input logic f, input logic cv, input logic cde,
                       input logic [REG_ADDR_W-1:0] cd, input logic [DATA_W-1:0] dat,
                       input logic bm);
    @(posedge clk);
    #1;
    disp_valid = v; disp_has_dst = hd; disp_dst = dst; disp_fence = f;
    cmt_valid = cv; cmt_dst_en = cde; cmt_dst = cd; cmt_data = dat;
    branch_miss_in = bm;
  endtask

  always @(negedge clk) begin
    if (disp_valid && disp_ready) begin
      if (disp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_dispatch: got id 0x%0h, expected no dispatch at %0t", disp_id, $time);
      end else begin
        mon_d = disp_q.pop_front();
        chk("mon_disp_id", 32'(disp_id), 32'(mon_d.id));
        chk("mon_rob_id", 32'(rob_id), 32'(mon_d.id));
        chk("mon_rsv", 32'(rsv), 32'(mon_d.rsv));
        chk("mon_rsv_addr", 32'(rsv_addr), 32'(mon_d.addr));
      end
    end
    if (we) begin
      if (cmt_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got wrData 0x%0h, expected no write at %0t", wrData, $time);
      end else begin
        mon_c = cmt_q.pop_front();
        chk("mon_wrData", 32'(wrData), 32'(mon_c));
      end
    end
  end

  initial begin
    // Reset held with hostile inputs: everything must read 0.
    drive(1, 1, 4'd6, 0, 1, 1, 4'd2, 16'h1234, 1);
    @(negedge clk);
    chk("rst_disp_ready", 32'(disp_ready), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_cmt_err", 32'(cmt_err), 0);
    chk("rst_disp_id", 32'(disp_id), 0);
    chk("rst_rsv_addr", 32'(rsv_addr), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_wrData", 32'(wrData), 0);
    chk("rst_branch_miss", 32'(branch_miss), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    #2 nrst = 1'b1;
    @(negedge clk);
    chk("post_rst_disp_id", 32'(disp_id), 1);
    chk("post_rst_ready", 32'(disp_ready), 1);

    // Fill the ROB: IDs 1..15, then full, then one commit frees a slot and ID wraps to 1.
    for (int i = 1; i <= 15; i++) begin
      drive(1, 1, 4'(i), 0, 0, 0, 0, 16'h0, 0);
      exp_disp(4'(i), 1'b1, 4'(i));
      @(negedge clk);
      chk("t1_inflight", 32'(inflight), 32'(i - 1));
    end
    drive(1, 1, 4'd7, 0, 0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("t1_full_ready", 32'(disp_ready), 0);
    chk("t1_full_inflight", 32'(inflight), 15);
    drive(1, 0, 4'd7, 0, 1, 1, 4'd2, 16'h1111, 0);
    exp_cmt(4'd2, 16'h1111);
    @(negedge clk);
    chk("t1_no_bypass_ready", 32'(disp_ready), 0);
    drive(1, 0, 4'd7, 0, 0, 0, 0, 16'h0, 0);
    exp_disp(4'd1, 1'b0, 4'd7);
    @(negedge clk);
    chk("t1_ready_after_cmt", 32'(disp_ready), 1);
    chk("t1_inflight_14", 32'(inflight), 14);

    // Commit without destination, then dispatch and commit together.
    drive(0, 0, 0, 0, 1, 0, 4'd9, 16'h2222, 0);
    @(negedge clk);
    chk("t2_we_no_dst", 32'(we), 0);
    drive(1, 1, 4'd5, 0, 1, 1, 4'd3, 16'hABCD, 0);
    exp_disp(4'd2, 1'b1, 4'd5);
    exp_cmt(4'd3, 16'hABCD);
    @(negedge clk);
    chk("t2_rsv", 32'(rsv), 1);
    chk("t2_we", 32'(we), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("t2_inflight_same", 32'(inflight), 14);

    // Drain to 3, then a fence must wait for an empty ROB.
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, 0, 0, 1, 1, 4'(i), 16'(16'h0100 + i), 0);
      exp_cmt(4'(i), 16'(16'h0100 + i));
    end
    drive(1, 0, 4'd1, 1, 0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("t3_fence_ready", 32'(disp_ready), 0);
    chk("t3_fence_inflight", 32'(inflight), 3);
    chk("t3_fence_state_run", 32'(state), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 4'd1, 1, 1, 1, 4'(10 + i), 16'(16'h0300 + i), 0);
      exp_cmt(4'(10 + i), 16'(16'h0300 + i));
      @(negedge clk);
      chk("t3_wait_state", 32'(state), 1);
      chk("t3_wait_ready", 32'(disp_ready), 0);
    end
    drive(1, 0, 4'd1, 1, 0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("t3_empty_state", 32'(state), 1);
    chk("t3_empty_inflight", 32'(inflight), 0);
    chk("t3_empty_ready", 32'(disp_ready), 0);
    drive(1, 0, 4'd1, 1, 0, 0, 0, 16'h0, 0);
    exp_disp(4'd3, 1'b0, 4'd1);
    @(negedge clk);
    chk("t3_run_state", 32'(state), 0);
    chk("t3_run_ready", 32'(disp_ready), 1);

    // Build inflight=6, then branch miss with concurrent commit and dispatch request.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 4'(i), 0, 0, 0, 0, 16'h0, 0);
      exp_disp(4'(4 + i), 1'b1, 4'(i));
    end
    drive(1, 1, 4'd8, 0, 1, 1, 4'd9, 16'h5555, 1);
    exp_cmt(4'd9, 16'h5555);
    @(negedge clk);
    chk("t4_inflight_6", 32'(inflight), 6);
    chk("t4_branch_miss", 32'(branch_miss), 1);
    chk("t4_ready", 32'(disp_ready), 0);
    chk("t4_rsv", 32'(rsv), 0);
    chk("t4_we", 32'(we), 1);
    drive(1, 1, 4'd8, 0, 0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("t4_flush_state", 32'(state), 2);
    chk("t4_flush_inflight", 32'(inflight), 0);
    chk("t4_flush_ready", 32'(disp_ready), 0);
    chk("t4_flush_bm_out", 32'(branch_miss), 0);
    drive(1, 1, 4'd8, 0, 0, 0, 0, 16'h0, 0);
    exp_disp(4'd9, 1'b1, 4'd8);
    @(negedge clk);
    chk("t4_run_state", 32'(state), 0);
    chk("t4_run_ready", 32'(disp_ready), 1);

    // Commit on an empty ROB is dropped and sets the sticky error.
    drive(0, 0, 0, 0, 1, 1, 4'd4, 16'h4444, 0);
    exp_cmt(4'd4, 16'h4444);
    @(negedge clk);
    chk("t5_inflight_1", 32'(inflight), 1);
    drive(0, 0, 0, 0, 1, 1, 4'd5, 16'h6666, 0);
    @(negedge clk);
    chk("t5_we_empty", 32'(we), 0);
    chk("t5_err_before", 32'(cmt_err), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("t5_err_set", 32'(cmt_err), 1);
    chk("t5_inflight_0", 32'(inflight), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("t5_err_held", 32'(cmt_err), 1);

    // Get into FENCE_WAIT with work in flight, then pulse reset mid-cycle.
    drive(1, 1, 4'd2, 0, 0, 0, 0, 16'h0, 0);
    exp_disp(4'd10, 1'b1, 4'd2);
    drive(1, 0, 4'd3, 1, 0, 0, 0, 16'h0, 0);
    drive(1, 0, 4'd3, 1, 0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("t6_state_wait", 32'(state), 1);
    chk("t6_inflight_1", 32'(inflight), 1);
    drive(1, 1, 4'd3, 1, 1, 1, 4'd6, 16'h7777, 0);
    #2 nrst = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state), 0);
    chk("t6_rst_inflight", 32'(inflight), 0);
    chk("t6_rst_cmt_err", 32'(cmt_err), 0);
    chk("t6_rst_ready", 32'(disp_ready), 0);
    chk("t6_rst_disp_id", 32'(disp_id), 0);
    chk("t6_rst_rob_id", 32'(rob_id), 0);
    chk("t6_rst_we", 32'(we), 0);
    chk("t6_rst_wrData", 32'(wrData), 0);
    chk("t6_rst_rsv", 32'(rsv), 0);
    chk("t6_rst_rsv_addr", 32'(rsv_addr), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    #2 nrst = 1'b1;
    @(negedge clk);
    chk("t6_post_disp_id", 32'(disp_id), 1);
    chk("t6_post_err", 32'(cmt_err), 0);

    chk("disp_q_drained", 32'(disp_q.size()), 0);
    chk("cmt_q_drained", 32'(cmt_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
